// File: rtl/fsk_period_demod.sv
// FSK period demodulator: times rising edges of signal_in, averages 2^AVG_LOG2 periods, slices to a bit.
// Optional macro GLITCH_REJECT_EN drops rises arriving sooner than MIN_PERIOD cycles after an accepted edge.
module fsk_period_demod #(
  parameter int CNT_W      = 16,
  parameter int AVG_LOG2   = 2,
  parameter int THRESH     = 51,
  parameter int TIMEOUT    = 1023,
  parameter int MIN_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             lost
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int WIN   = 1 << AVG_LOG2;

`ifdef GLITCH_REJECT_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_reg, state_next;

  // [0],[1] synchronize the asynchronous input; [2] is the delayed copy for edge detection
  logic [2:0] sync_reg;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             pvalid_reg, pvalid_next;
  logic             lost_reg, lost_next;
  logic             win_done_reg, win_done_next;
  logic             bit_calc_reg, bit_calc_next;
  logic             bit_reg, bit_next;
  logic             bvalid_reg, bvalid_next;

  logic             rise;
  logic             glitch;
  logic             start;
  logic             accept;
  logic             expire;
  logic             last;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] avg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], signal_in};
    end
  end

  assign rise   = sync_reg[1] & ~sync_reg[2];
  assign glitch = GLITCH_EN && (cnt_reg < CNT_W'(MIN_PERIOD));
  assign start  = (state_reg == IDLE) && rise;
  assign accept = (state_reg == RUN) && rise && !glitch;
  // an accepted edge on the timeout cycle takes priority over the timeout
  assign expire = (state_reg == RUN) && !accept && (cnt_reg == CNT_W'(TIMEOUT));
  assign last   = (idx_reg == IDX_W'(WIN - 1));
  assign sum    = acc_reg + ACC_W'(cnt_reg);
  assign avg    = sum >> AVG_LOG2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next      = cnt_reg;
    acc_next      = acc_reg;
    idx_next      = idx_reg;
    period_next   = period_reg;
    pvalid_next   = 1'b0;
    lost_next     = lost_reg;
    win_done_next = 1'b0;
    bit_calc_next = bit_calc_reg;
    bit_next      = bit_reg;
    bvalid_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = start ? CNT_W'(1) : '0;
      end
      RUN: begin
        if (accept) begin
          cnt_next    = CNT_W'(1);
          period_next = cnt_reg;
          pvalid_next = 1'b1;
          lost_next   = 1'b0;
          if (last) begin
            acc_next      = '0;
            idx_next      = '0;
            win_done_next = 1'b1;
            bit_calc_next = (avg > ACC_W'(THRESH)) ? 1'b0 : 1'b1;
          end else begin
            acc_next = sum;
            idx_next = idx_reg + IDX_W'(1);
          end
        end else if (expire) begin
          cnt_next  = '0;
          acc_next  = '0;
          idx_next  = '0;
          lost_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        cnt_next = '0;
      end
    endcase

    // the bit is published one cycle after the period that closed its window
    if (win_done_reg) begin
      bit_next    = bit_calc_reg;
      bvalid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      idx_reg      <= '0;
      period_reg   <= '0;
      pvalid_reg   <= 1'b0;
      lost_reg     <= 1'b0;
      win_done_reg <= 1'b0;
      bit_calc_reg <= 1'b0;
      bit_reg      <= 1'b0;
      bvalid_reg   <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      idx_reg      <= idx_next;
      period_reg   <= period_next;
      pvalid_reg   <= pvalid_next;
      lost_reg     <= lost_next;
      win_done_reg <= win_done_next;
      bit_calc_reg <= bit_calc_next;
      bit_reg      <= bit_next;
      bvalid_reg   <= bvalid_next;
    end
  end

  assign period_out   = period_reg;
  assign period_valid = pvalid_reg;
  assign bit_out      = bit_reg;
  assign bit_valid    = bvalid_reg;
  assign lost         = lost_reg;

endmodule

// File: doc/fsk_period_demod.md
Name: fsk_period_demod

Overview:
- Downstream consumer of the digital modulator output `signal`, which alternates between two frequencies.
- Measures the spacing between successive rising edges of `signal` in `clk` cycles and averages 2^AVG_LOG2 periods.
- Compares the average against a threshold and emits one recovered bit per averaging window.
- Also reports each raw period and flags loss of signal. Sits between the modulator output and the TDC/readout logic.

Parameters:
- CNT_W, 16, period counter width.
- AVG_LOG2, 2, log2 of number of periods averaged per bit (4 periods).
- THRESH, 51, average period (clk cycles) above which bit = 0; at or below, bit = 1.
- TIMEOUT, 1023, clk cycles without an edge before loss of signal; must be < 2^CNT_W-1.
- MIN_PERIOD, 8, shortest accepted period; used only with GLITCH_REJECT_EN.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset, synchronous, active-low.
- signal_in, input, 1, modulated signal; treated as asynchronous.
- period_out, output, CNT_W, last measured period in clk cycles.
- period_valid, output, 1, one-cycle pulse when period_out updates.
- bit_out, output, 1, last recovered bit.
- bit_valid, output, 1, one-cycle pulse when bit_out updates.
- lost, output, 1, loss-of-signal flag.

Behaviour:
- Reset: sampled on posedge clk while rst=0.
  - Clears all outputs to 0: period_out, period_valid, bit_out, bit_valid, lost.
  - Clears the synchronizer, counter, accumulator and window index.
  - Sets state to IDLE.
  - Reset mid-window discards the partial window.
- Input path: 2-flop synchronizer followed by a delay flop. rise = s2 & ~s_d. A rise is seen 3 clk cycles after the input edge.
- State IDLE:
  - cnt=0.
  - On rise: go to RUN, cnt<=1. No period is reported, since the first edge has no reference.
- State RUN:
  - cnt increments by 1 per cycle.
  - On rise: period_out<=cnt, period_valid=1 next cycle, cnt<=1.
  - An edge P cycles after the previous one reports exactly P.
- Accumulation:
  - Each accepted period is added to acc (width CNT_W+AVG_LOG2). The window index increments.
  - When the index wraps after the 2^AVG_LOG2-th period: avg = acc >> AVG_LOG2 (truncating), bit_out <= (avg > THRESH) ? 0 : 1.
  - bit_valid pulses one cycle after the final period_valid of the window.
  - acc and index then clear.
- Timeout: in RUN, if cnt == TIMEOUT and no rise occurs that cycle:
  - state <= IDLE, lost <= 1.
  - acc and index clear; no period_valid or bit_valid is produced.
- lost: stays 1 until the next period_valid, then clears in the same cycle period_valid asserts.
- Simultaneous rise and cnt == TIMEOUT: the rise wins; the period is reported normally and there is no timeout.
- Counter cannot wrap, because TIMEOUT bounds it.
- period_valid and bit_valid are never high in the same cycle for the same window boundary. bit_valid lags by one cycle.
- Throughput: one period per edge.
  - Minimum edge spacing is 2 cycles, set by the edge-detect.
  - Closer edges merge in the synchronizer; the bench does not rely on them.

Optional Feature:
- Macro: GLITCH_REJECT_EN.
- Defined: in RUN, a rise with cnt < MIN_PERIOD is ignored.
  - No capture, no period_valid.
  - cnt keeps counting from the earlier accepted edge.
- Not defined: every rise in RUN is accepted; MIN_PERIOD is unused.

Test Plan:
- Reset: hold rst=0 for 5 cycles with signal_in toggling -> all outputs 0 and no pulses; after release, the first rise gives no period_valid.
- Square wave with period 50 clk, 6 rising edges -> period_valid 5 times with period_out=50; after the 4th report, bit_valid one cycle later with bit_out=1; lost=0 throughout.
- Square wave with period 54 clk, 5 edges -> period_out=54 ×4; bit_valid with bit_out=0. Mixed window 50,50,54,54 -> avg 52 > 51 -> bit_out=0.
- Stop signal_in after 2 periods of 50 -> exactly TIMEOUT cycles after the last rise, lost=1 with no bit_valid. Restart at period 50:
  - first edge gives no report;
  - second edge gives period_valid, period_out=50, lost clears;
  - bit after 4 fresh periods.
- Reset mid-operation: assert rst for 1 cycle after 3 periods of 50 -> no bit_valid from the partial window; the next bit_valid comes only after 4 new reported periods.
- Glitch between edges (period 50, extra rise 3 cycles after an edge):
  - with GLITCH_REJECT_EN, MIN_PERIOD=8: reports 50 only;
  - without the macro: reports 3 then 47.
